// File: rtl/sram_pkg.sv
// Shared definitions for the dual-port buffer: the clear FSM encoding and the
// supported read-latency range.
package sram_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
endpackage

// File: rtl/sram_clear_ctrl.sv
// Clear sequencer: once started, it sweeps every address exactly once, writing
// zero, and holds busy for the length of the sweep.
module sram_clear_ctrl
  import sram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_start,
  output logic                     busy,
  output logic                     clr_we,
  output logic [ADDRESS_WIDTH-1:0] clr_addr
);
  clr_state_e               state_q;
  logic                     busy_q;
  logic [ADDRESS_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (clr_start) begin
          state_q <= ST_CLEAR;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
        ST_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          // The counter wraps to zero on the last address, ready for the next clear.
          if (&cnt_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = busy_q;
  assign clr_addr = cnt_q;
endmodule

// File: rtl/sram_dp_buf.sv
// Dual-port (1W/1R) buffer with write-first bypass, a 1- or 2-stage registered
// read pipeline, and a background clear that zeroes the whole array.
module sram_dp_buf
  import sram_pkg::*;
#(
  parameter int    DATA_WIDTH    = 16,
  parameter int    ADDRESS_WIDTH = 3,
  parameter string INIT_FILE     = "",
  parameter int    READ_LATENCY  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            chip_sel,
  input  logic                            wr_en,
  input  logic        [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic signed [DATA_WIDTH-1:0]    wr_data,
  input  logic                            rd_en,
  input  logic        [ADDRESS_WIDTH-1:0] rd_addr,
  output logic signed [DATA_WIDTH-1:0]    rd_data,
  output logic                            rd_valid,
  input  logic                            clr_start,
  output logic                            busy
);
  localparam int RAM_DEPTH = 2 ** ADDRESS_WIDTH;

  if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_lat
    $error("sram_dp_buf: READ_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                     clr_we;
  logic [ADDRESS_WIDTH-1:0] clr_addr;

  sram_clear_ctrl #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_start(clr_start),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_word;

  assign wr_acc  = chip_sel && wr_en && !busy;
  assign rd_acc  = chip_sel && rd_en && !busy;
  assign rd_word = (wr_acc && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];

  // Array has no reset so contents survive rst; clear and user writes never coincide.
  always_ff @(posedge clk) begin
    if (clr_we)      mem[clr_addr] <= '0;
    else if (wr_acc) mem[wr_addr]  <= wr_data;
  end

  logic [READ_LATENCY-1:0]                 vld_pipe_d, vld_pipe_q;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] dat_pipe_d, dat_pipe_q;

  // Each stage only loads when a valid result moves into it, so the output
  // stage holds its last value between reads.
  always_comb begin
    vld_pipe_d    = '0;
    dat_pipe_d    = dat_pipe_q;
    vld_pipe_d[0] = rd_acc;
    if (rd_acc) dat_pipe_d[0] = rd_word;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      if (vld_pipe_q[i-1]) dat_pipe_d[i] = dat_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
    end
  end

  assign rd_valid = vld_pipe_q[READ_LATENCY-1];
  assign rd_data  = dat_pipe_q[READ_LATENCY-1];
endmodule
